rsc_encoder_tx: RTL

Constituent recursive systematic convolutional encoder, the transmit-side counterpart of the SISO decoder front end. It takes a block of information bits and runs the 8-state LTE trellis (feedback 1+D²+D³, parity 1+D+D³), terminating it with 3 tail steps. It BPSK-maps the systematic and parity bits to signed 16-bit soft values and emits them as one interleaved word stream: systematic first, then parity, per trellis step. The output matches the 16-bit sys/parity alternation the decoder's `in`/`valid_in` port consumes.

---
 rtl/siso_pkg.sv | 34 +++
 rtl/rsc_core.sv | 30 +++
 rtl/rsc_encoder_tx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/siso_pkg.sv
// Shared types and helpers for the LTE constituent RSC encoder: trellis step and BPSK mapping.
package siso_pkg;

  localparam int TAIL_LEN = 3;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL,
    FLUSH
  } enc_state_e;

  typedef struct packed {
    logic       u_eff;
    logic       p;
    logic [2:0] s_next;
  } rsc_step_t;

  // s = {s1,s2,s3}; feedback 1+D^2+D^3, parity 1+D+D^3. Tail input cancels the feedback.
  function automatic rsc_step_t rsc_step(input logic u, input logic [2:0] s, input logic tail);
    rsc_step_t r;
    logic      f;
    r.u_eff  = tail ? (s[1] ^ s[0]) : u;
    f        = r.u_eff ^ s[1] ^ s[0];
    r.p      = f ^ s[2] ^ s[0];
    r.s_next = {f, s[2], s[1]};
    return r;
  endfunction

  function automatic logic [15:0] bpsk_map(input logic b, input logic signed [15:0] amp);
    return b ? 16'(-amp) : 16'(amp);
  endfunction

endpackage

// File: rtl/rsc_core.sv
// Registered trellis state around the combinational RSC step.
module rsc_core
  import siso_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic       u,
  input  logic       tail,
  output logic       u_eff,
  output logic       p,
  output logic [2:0] s
);

  rsc_step_t step;

  assign step  = rsc_step(u, s, tail);
  assign u_eff = step.u_eff;
  assign p     = step.p;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s <= 3'b000;
    end else if (load) begin
      s <= step.s_next;
    end
  end

endmodule

// File: rtl/rsc_encoder_tx.sv
// RSC encoder transmit front end: block FSM, trellis termination and a sys/parity output slot.
// Handshakes: a transfer happens on a rising edge where valid && ready; the source holds its
// payload stable while valid is high and ready is low, and ready never depends on the same-cycle
// payload.
module rsc_encoder_tx
  import siso_pkg::*;
#(
  parameter logic signed [15:0] AMP = 16'sd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] blklen,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  output logic [15:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_par,
  output logic        out_last,
  output logic        done
);

  enc_state_e  state, next_state;
  logic [15:0] cnt;
  logic [15:0] blklen_q;
  logic [1:0]  tail_cnt;
  logic        par_pend;
  logic        par_bit;
  logic        par_last;

  logic        start_ok;
  logic        out_fire;
  logic        step_ok;
  logic        data_step;
  logic        tail_step;
  logic        step;
  logic        core_u_eff;
  logic        core_p;
  logic [2:0]  core_s;

  rsc_core u_core (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .load  (step),
    .u     (bit_in),
    .tail  (state == TAIL),
    .u_eff (core_u_eff),
    .p     (core_p),
    .s     (core_s)
  );

  always_comb begin
    start_ok   = (state == IDLE) && start && (blklen != 16'd0);
    out_fire   = out_valid && out_ready;
    // A step may only overwrite the slot once the parity half of the previous step is gone.
    step_ok    = !par_pend && (!out_valid || out_ready);
    bit_ready  = (state == DATA) && step_ok;
    data_step  = bit_ready && bit_valid;
    tail_step  = (state == TAIL) && step_ok;
    step       = data_step || tail_step;
    next_state = state;
    case (state)
      IDLE:  if (start_ok) next_state = DATA;
      DATA:  if (data_step && (cnt == blklen_q - 16'd1)) next_state = TAIL;
      TAIL:  if (tail_step && (tail_cnt == 2'(TAIL_LEN - 1))) next_state = FLUSH;
      FLUSH: if (out_fire && out_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 16'd0;
      blklen_q <= 16'd0;
      tail_cnt <= 2'd0;
      done     <= 1'b0;
    end else begin
      state <= next_state;
      done  <= out_fire && out_last;
      if (start_ok) begin
        cnt      <= 16'd0;
        blklen_q <= blklen;
        tail_cnt <= 2'd0;
      end else begin
        if (data_step) cnt <= cnt + 16'd1;
        if (tail_step) tail_cnt <= tail_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= 16'd0;
      out_valid  <= 1'b0;
      out_is_par <= 1'b0;
      out_last   <= 1'b0;
      par_pend   <= 1'b0;
      par_bit    <= 1'b0;
      par_last   <= 1'b0;
    end else if (step) begin
      out        <= bpsk_map(core_u_eff, AMP);
      out_valid  <= 1'b1;
      out_is_par <= 1'b0;
      out_last   <= 1'b0;
      par_pend   <= 1'b1;
      par_bit    <= core_p;
      par_last   <= tail_step && (tail_cnt == 2'(TAIL_LEN - 1));
    end else if (out_fire) begin
      if (par_pend) begin
        out        <= bpsk_map(par_bit, AMP);
        out_is_par <= 1'b1;
        out_last   <= par_last;
        par_pend   <= 1'b0;
      end else begin
        out        <= 16'd0;
        out_valid  <= 1'b0;
        out_is_par <= 1'b0;
        out_last   <= 1'b0;
      end
    end
  end

endmodule
